// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction fetch / pipeline hazard controller
//
// Purpose:
//   Sequences instruction fetch after reset and coordinates next-PC selection,
//   PC/IF-ID stalls and IF-ID/ID-EX flushes. It handles EX-stage redirects
//   (JALR > JAL > taken branch), ID-stage load-use hazards and an
//   outstanding fetch that a redirect has made stale. It also keeps two
//   saturating performance counters.
//
// Ports:
//   clk             in   sole clock, rising edge
//   rst             in   asynchronous active-low reset
//   imem_req        out  fetch request for the current PC
//   imem_ack        in   one-cycle pulse: instruction at current PC valid
//   ld_use_hazard   in   ID-stage load-use hazard
//   ex_branch_taken in   EX-stage conditional branch resolved taken
//   ex_is_jal       in   EX-stage JAL
//   ex_is_jalr      in   EX-stage JALR
//   npc_op          out  next-PC select: PLUS4=000 BRANCH=001 JUMP=010 JALR=100
//   pc_stall        out  hold PC register
//   stall_ifid      out  hold IF/ID register
//   flush_ifid      out  bubble into IF/ID
//   flush_idex      out  bubble into ID/EX
//   redir_cnt       out  saturating count of FETCH-state redirects
//   stall_cnt       out  saturating count of FETCH-state cycles with pc_stall=1

module fetch_ctrl #(
    parameter int BOOT_CYCLES = 2,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    input  logic             imem_ack,
    input  logic             ld_use_hazard,
    input  logic             ex_branch_taken,
    input  logic             ex_is_jal,
    input  logic             ex_is_jalr,
    output logic [2:0]       npc_op,
    output logic             pc_stall,
    output logic             stall_ifid,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic [CNT_W-1:0] redir_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [1:0] ST_BOOT  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam logic [2:0] NPC_PLUS4  = 3'b000;
    localparam logic [2:0] NPC_BRANCH = 3'b001;
    localparam logic [2:0] NPC_JUMP   = 3'b010;
    localparam logic [2:0] NPC_JALR   = 3'b100;

    // Last boot-counter value; BOOT lasts BOOT_CYCLES cycles counting from 0.
    localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [1:0]       r_state;
    logic [3:0]       r_boot_cnt;
    logic [CNT_W-1:0] r_redir_cnt;
    logic [CNT_W-1:0] r_stall_cnt;

    logic [1:0]       w_next_state;
    logic             w_redirect;
    logic             w_in_fetch;
    logic             w_boot_done;
    logic             w_redir_inc;
    logic             w_stall_inc;

    assign w_redirect  = ex_is_jalr | ex_is_jal | ex_branch_taken;
    assign w_in_fetch  = (r_state == ST_FETCH);
    assign w_boot_done = (r_boot_cnt == BOOT_LAST);

    // Counters only observe FETCH; redirects seen in BOOT or DRAIN belong to
    // instructions that are already being discarded.
    assign w_redir_inc = w_in_fetch & w_redirect;
    assign w_stall_inc = w_in_fetch & pc_stall;

    // Control outputs are purely combinational so that a redirect or hazard
    // steers the PC mux in the same cycle EX/ID raises it.
    always_comb begin
        imem_req     = 1'b0;
        npc_op       = NPC_PLUS4;
        pc_stall     = 1'b0;
        stall_ifid   = 1'b0;
        flush_ifid   = 1'b0;
        flush_idex   = 1'b0;
        w_next_state = r_state;

        case (r_state)
            ST_BOOT: begin
                pc_stall   = 1'b1;
                flush_ifid = 1'b1;
                if (w_boot_done) begin
                    w_next_state = ST_FETCH;
                end
            end

            ST_FETCH: begin
                imem_req = 1'b1;
                if (w_redirect) begin
                    // Redirect wins over the load-use hazard: the stalled
                    // instruction is being flushed anyway.
                    if (ex_is_jalr) begin
                        npc_op = NPC_JALR;
                    end else if (ex_is_jal) begin
                        npc_op = NPC_JUMP;
                    end else begin
                        npc_op = NPC_BRANCH;
                    end
                    flush_ifid = 1'b1;
                    flush_idex = 1'b1;
                    // Without an ack the fetch in flight is for the old path;
                    // its late ack must be swallowed in DRAIN.
                    if (!imem_ack) begin
                        w_next_state = ST_DRAIN;
                    end
                end else if (ld_use_hazard) begin
                    pc_stall   = 1'b1;
                    stall_ifid = 1'b1;
                    flush_idex = 1'b1;
                end else begin
                    pc_stall   = ~imem_ack;
                    flush_ifid = ~imem_ack;
                end
            end

            ST_DRAIN: begin
                pc_stall   = 1'b1;
                flush_ifid = 1'b1;
                if (imem_ack) begin
                    w_next_state = ST_FETCH;
                end
            end

            default: begin
                pc_stall     = 1'b1;
                flush_ifid   = 1'b1;
                w_next_state = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_BOOT;
            r_boot_cnt <= 4'd0;
        end else begin
            r_state <= w_next_state;
            if (r_state == ST_BOOT && !w_boot_done) begin
                r_boot_cnt <= r_boot_cnt + 4'd1;
            end else begin
                r_boot_cnt <= 4'd0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_redir_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_redir_inc && r_redir_cnt != CNT_MAX) begin
                r_redir_cnt <= r_redir_cnt + CNT_ONE;
            end
            if (w_stall_inc && r_stall_cnt != CNT_MAX) begin
                r_stall_cnt <= r_stall_cnt + CNT_ONE;
            end
        end
    end

    assign redir_cnt = r_redir_cnt;
    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - self-checking bench for fetch_ctrl
module tb_fetch_ctrl;

    localparam int BOOT_CYCLES = 2;
    localparam int M_BOOT  = 0;
    localparam int M_FETCH = 1;
    localparam int M_DRAIN = 2;
    localparam logic [7:0] RESET_CTL = 8'b0_000_1_0_1_0;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic ack = 1'b0, hz = 1'b0, br = 1'b0, jal = 1'b0, jalr = 1'b0;

    logic        req, pcs, sif, fif, fie;
    logic [2:0]  npc;
    logic [15:0] rcnt, scnt;
    logic        req4, pcs4, sif4, fif4, fie4;
    logic [2:0]  npc4;
    logic [3:0]  rcnt4, scnt4;

    logic [7:0] act, act4;
    assign act  = {req, npc, pcs, sif, fif, fie};
    assign act4 = {req4, npc4, pcs4, sif4, fif4, fie4};

    int checks = 0;
    int errors = 0;

    int m_mode, m_boot, m_redirs, m_stalls;

    always #5 clk = ~clk;

    fetch_ctrl #(.BOOT_CYCLES(BOOT_CYCLES), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .imem_req(req), .imem_ack(ack),
        .ld_use_hazard(hz), .ex_branch_taken(br), .ex_is_jal(jal), .ex_is_jalr(jalr),
        .npc_op(npc), .pc_stall(pcs), .stall_ifid(sif), .flush_ifid(fif), .flush_idex(fie),
        .redir_cnt(rcnt), .stall_cnt(scnt)
    );

    fetch_ctrl #(.BOOT_CYCLES(BOOT_CYCLES), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .imem_req(req4), .imem_ack(ack),
        .ld_use_hazard(hz), .ex_branch_taken(br), .ex_is_jal(jal), .ex_is_jalr(jalr),
        .npc_op(npc4), .pc_stall(pcs4), .stall_ifid(sif4), .flush_ifid(fif4), .flush_idex(fie4),
        .redir_cnt(rcnt4), .stall_cnt(scnt4)
    );

    function automatic int sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    // Expected {imem_req, npc_op, pc_stall, stall_ifid, flush_ifid, flush_idex}
    function automatic logic [7:0] exp_ctl();
        logic       r_req, r_pcs, r_sif, r_fif, r_fie;
        logic [2:0] r_npc;
        r_req = 0; r_pcs = 0; r_sif = 0; r_fif = 0; r_fie = 0; r_npc = 3'b000;
        if (m_mode == M_FETCH) begin
            r_req = 1;
            if (jalr || jal || br) begin
                r_npc = jalr ? 3'b100 : (jal ? 3'b010 : 3'b001);
                r_fif = 1; r_fie = 1;
            end else if (hz) begin
                r_pcs = 1; r_sif = 1; r_fie = 1;
            end else begin
                r_pcs = !ack; r_fif = !ack;
            end
        end else begin
            r_pcs = 1; r_fif = 1;
        end
        return {r_req, r_npc, r_pcs, r_sif, r_fif, r_fie};
    endfunction

    task automatic model_reset();
        m_mode = M_BOOT; m_boot = 0; m_redirs = 0; m_stalls = 0;
    endtask

    task automatic model_tick();
        logic [7:0] e;
        e = exp_ctl();
        if (!rst) begin
            model_reset();
        end else if (m_mode == M_BOOT) begin
            m_boot++;
            if (m_boot == BOOT_CYCLES) m_mode = M_FETCH;
        end else if (m_mode == M_FETCH) begin
            if (jalr || jal || br) m_redirs++;
            if (e[3]) m_stalls++;
            if ((jalr || jal || br) && !ack) m_mode = M_DRAIN;
        end else begin
            if (ack) m_mode = M_FETCH;
        end
    endtask

    task automatic drive(input logic a, input logic h, input logic b, input logic j, input logic jr);
        ack = a; hz = h; br = b; jal = j; jalr = jr;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        model_reset();
        drive(1, 1, 1, 1, 1);
        checks++;
        if (act !== RESET_CTL) begin errors++; $display("FAIL reset_ctl got=%b exp=%b", act, RESET_CTL); end
        checks++;
        if (rcnt !== 16'd0 || scnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", rcnt, scnt); end
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_boot();
        for (int c = 1; c <= 4; c++) begin
            drive(1, 0, 0, 0, 0);
            checks++;
            if (req !== (c > 2)) begin errors++; $display("FAIL boot_req cyc=%0d got=%b exp=%b", c, req, (c > 2)); end
            checks++;
            if (pcs !== (c <= 2)) begin errors++; $display("FAIL boot_pc_stall cyc=%0d got=%b exp=%b", c, pcs, (c <= 2)); end
            tick();
        end
    endtask

    task automatic test_hazard();
        drive(1, 1, 0, 0, 0);
        checks++;
        if ({pcs, sif, fie, fif} !== 4'b1110) begin errors++; $display("FAIL hazard_ctl got=%b exp=1110", {pcs, sif, fie, fif}); end
        tick();
        drive(1, 0, 0, 0, 0);
        checks++;
        if (scnt !== 16'd1) begin errors++; $display("FAIL hazard_stall_cnt got=%0d exp=1", scnt); end
        tick();
    endtask

    task automatic test_priority();
        drive(1, 1, 1, 0, 1);
        checks++;
        if ({npc, fif, fie, pcs} !== 6'b100_1_1_0) begin errors++; $display("FAIL prio_ctl got=%b exp=100110", {npc, fif, fie, pcs}); end
        tick();
        drive(1, 0, 0, 0, 0);
        checks++;
        if (rcnt !== 16'd1) begin errors++; $display("FAIL prio_redir_cnt got=%0d exp=1", rcnt); end
        checks++;
        if (req !== 1'b1 || pcs !== 1'b0) begin errors++; $display("FAIL prio_stay_fetch got=%b%b exp=10", req, pcs); end
        tick();
    endtask

    task automatic test_drain();
        drive(0, 0, 0, 1, 0);
        checks++;
        if (npc !== 3'b010) begin errors++; $display("FAIL drain_jal_npc got=%b exp=010", npc); end
        tick();
        for (int c = 1; c <= 3; c++) begin
            drive(c == 3, 0, 0, 0, 0);
            checks++;
            if ({req, fif, pcs, npc} !== 6'b0_1_1_000) begin errors++; $display("FAIL drain_ctl cyc=%0d got=%b exp=011000", c, {req, fif, pcs, npc}); end
            tick();
        end
        drive(1, 0, 0, 0, 0);
        checks++;
        if (req !== 1'b1) begin errors++; $display("FAIL drain_exit got=%b exp=1", req); end
        tick();
    endtask

    task automatic test_saturation();
        int sel;
        for (int i = 0; i < 20; i++) begin
            sel = $urandom_range(1, 7);
            drive(1, $urandom_range(0, 1), sel[0], sel[1], sel[2]);
            tick();
        end
        drive(1, 0, 0, 0, 0);
        checks++;
        if (rcnt4 !== 4'd15) begin errors++; $display("FAIL sat_redir_cnt4 got=%0d exp=15", rcnt4); end
        checks++;
        if (rcnt !== 16'(sat(m_redirs, 16))) begin errors++; $display("FAIL sat_redir_cnt16 got=%0d exp=%0d", rcnt, sat(m_redirs, 16)); end
        tick();
    endtask

    task automatic test_random();
        logic [7:0] e;
        for (int i = 0; i < 1500; i++) begin
            drive($urandom_range(0, 99) < 50, $urandom_range(0, 99) < 25,
                  $urandom_range(0, 99) < 12, $urandom_range(0, 99) < 10,
                  $urandom_range(0, 99) < 8);
            e = exp_ctl();
            checks++;
            if (act !== e) begin errors++; $display("FAIL rand_ctl cyc=%0d got=%b exp=%b", i, act, e); end
            checks++;
            if (act4 !== e) begin errors++; $display("FAIL rand_ctl4 cyc=%0d got=%b exp=%b", i, act4, e); end
            checks++;
            if (rcnt !== 16'(sat(m_redirs, 16)) || scnt !== 16'(sat(m_stalls, 16))) begin
                errors++; $display("FAIL rand_cnt16 cyc=%0d got=%0d/%0d exp=%0d/%0d", i, rcnt, scnt, m_redirs, m_stalls);
            end
            checks++;
            if (rcnt4 !== 4'(sat(m_redirs, 4)) || scnt4 !== 4'(sat(m_stalls, 4))) begin
                errors++; $display("FAIL rand_cnt4 cyc=%0d got=%0d/%0d exp=%0d/%0d", i, rcnt4, scnt4, sat(m_redirs, 4), sat(m_stalls, 4));
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_drain();
        int guard;
        guard = 0;
        while (m_mode != M_FETCH && guard < 20) begin
            drive(1, 0, 0, 0, 0);
            tick();
            guard++;
        end
        checks++;
        if (m_mode != M_FETCH) begin errors++; $display("FAIL mid_reset_reach_fetch got=%0d exp=%0d", m_mode, M_FETCH); end
        drive(0, 0, 1, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0);
        checks++;
        if ({req, fif, pcs} !== 3'b011) begin errors++; $display("FAIL mid_reset_in_drain got=%b exp=011", {req, fif, pcs}); end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (act !== RESET_CTL || act4 !== RESET_CTL) begin errors++; $display("FAIL mid_reset_ctl got=%b/%b exp=%b", act, act4, RESET_CTL); end
        checks++;
        if (rcnt !== 16'd0 || scnt !== 16'd0 || rcnt4 !== 4'd0 || scnt4 !== 4'd0) begin
            errors++; $display("FAIL mid_reset_cnt got=%0d/%0d/%0d/%0d exp=0", rcnt, scnt, rcnt4, scnt4);
        end
        ack = 1'b1;
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            drive(1, 0, 0, 0, 0);
            checks++;
            if (req !== (c > 2)) begin errors++; $display("FAIL rereset_boot_req cyc=%0d got=%b exp=%b", c, req, (c > 2)); end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_boot();
        test_hazard();
        test_priority();
        test_drain();
        test_saturation();
        test_random();
        test_reset_mid_drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter BOOT_CYCLES, default 2: cycles PC is held after reset release (legal 1..15).
REQ-002 SHALL have parameter CNT_W, default 16: width of the performance counters.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port imem_req  output  1  fetch request for the current PC.
REQ-006 SHALL have port imem_ack  input  1  single-cycle pulse: instruction at current PC valid this cycle.
REQ-007 SHALL have port ld_use_hazard  input  1  ID-stage load-use hazard.
REQ-008 SHALL have port ex_branch_taken  input  1  EX-stage conditional branch resolved taken.
REQ-009 SHALL have port ex_is_jal  input  1  EX-stage JAL.
REQ-010 SHALL have port ex_is_jalr  input  1  EX-stage JALR.
REQ-011 SHALL have port npc_op  output  3  next-PC select: PLUS4=000, BRANCH=001, JUMP=010, JALR=100.
REQ-012 SHALL have port pc_stall  output  1  holds the PC register when 1.
REQ-013 SHALL have port stall_ifid  output  1  holds the IF/ID register.
REQ-014 SHALL have port flush_ifid  output  1  loads a bubble into IF/ID.
REQ-015 SHALL have port flush_idex  output  1  loads a bubble into ID/EX.
REQ-016 SHALL have port redir_cnt  output  CNT_W  saturating count of redirects.
REQ-017 SHALL have port stall_cnt  output  CNT_W  saturating count of FETCH-state cycles with pc_stall=1.

Function
REQ-018 SHALL implement FSM states BOOT, FETCH and DRAIN; all control outputs SHALL be combinational from state and inputs.
REQ-019 BOOT: imem_req=0, pc_stall=1, flush_ifid=1; internal counter SHALL advance each cycle; move to FETCH after BOOT_CYCLES cycles.
REQ-020 FETCH: imem_req=1; npc_op=PLUS4 unless a redirect is active.
REQ-021 A redirect SHALL be active when ex_is_jalr, ex_is_jal or ex_branch_taken is 1; priority SHALL be jalr > jal > branch, giving npc_op JALR, JUMP or BRANCH respectively.
REQ-022 Redirect in FETCH: pc_stall=0, flush_ifid=1, flush_idex=1, stall_ifid=0; ld_use_hazard SHALL be ignored that cycle.
REQ-023 Redirect in FETCH with imem_ack=0: next state SHALL be DRAIN; with imem_ack=1: remain in FETCH.
REQ-024 No redirect, ld_use_hazard=1: pc_stall=1, stall_ifid=1, flush_idex=1, flush_ifid=0, regardless of imem_ack.
REQ-025 No redirect, no hazard: pc_stall = NOT imem_ack; flush_ifid = NOT imem_ack; stall_ifid=0, flush_idex=0.
REQ-026 DRAIN: imem_req=0, pc_stall=1, flush_ifid=1, npc_op=PLUS4; on imem_ack=1 the instruction SHALL be discarded and the FSM SHALL go to FETCH.
REQ-027 A redirect in DRAIN or BOOT SHALL be ignored: no flush_idex, no count.
REQ-028 redir_cnt SHALL increment by 1 per FETCH-state cycle with an active redirect and saturate at all-ones.
REQ-029 stall_cnt SHALL increment by 1 per FETCH-state cycle with pc_stall=1 and saturate at all-ones.
REQ-030 Outputs not named for a state SHALL be 0.

Reset
REQ-031 While rst=0 the FSM SHALL be BOOT, the boot counter 0, and redir_cnt and stall_cnt 0.
REQ-032 Reset outputs SHALL be imem_req=0, pc_stall=1, flush_ifid=1, npc_op=000 and all other outputs 0.
REQ-033 Reset asserted mid-DRAIN or mid-FETCH SHALL take effect immediately, without waiting for a clock edge; a pending ack SHALL be forgotten.

Verification
REQ-034 Release rst, hold imem_ack=1 -> imem_req=0 for exactly 2 cycles, then 1; pc_stall falls to 0 on cycle 3.
REQ-035 FETCH, imem_ack=1, assert ld_use_hazard for 1 cycle -> pc_stall=1, stall_ifid=1, flush_idex=1 that cycle; stall_cnt=1.
REQ-036 FETCH, ex_is_jalr=1 and ex_branch_taken=1 together, imem_ack=1 -> npc_op=100, both flushes=1, pc_stall=0; redir_cnt=1; stays in FETCH.
REQ-037 FETCH, ex_is_jal=1 with imem_ack=0, ack arrives 3 cycles later -> DRAIN for 3 cycles with imem_req=0 and flush_ifid=1, then FETCH.
REQ-038 CNT_W=4, 20 back-to-back redirects with imem_ack=1 -> redir_cnt saturates at 15.
REQ-039 Drop rst mid-DRAIN -> outputs take REQ-032 values immediately and counters=0.
